iob_be_mem_sim: RTL and testbench

Parametrised simulation back-end memory model for the IOb native interface; it replaces the fixed single-cycle RAM plus always-ready stub behind the cache back-end in simulation wrappers.
- Adds configurable read latency with fully pipelined outstanding reads.
- Adds deterministic back-pressure (periodic ready stalls) so cache miss, write-through and stall paths get exercised.
- Sits between the cache back-end port and nothing else (leaf model).

---
 rtl/iob_be_mem_sim.sv | 211 +++++++++++++++++++++
 tb/tb_iob_be_mem_sim.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_be_mem_sim.sv
// iob_be_mem_sim: simulation back-end memory for the IOb native interface.
// Word-addressed RAM with byte strobes, RD_LAT-cycle pipelined read responses
// and a periodic ready_o stall pattern that exercises the requester's
// back-pressure handling.
// Optional feature: define IOB_BE_MEM_SIM_PROTOCOL_CHECK_EN to build a checker
// that sets a sticky error_o when a stalled request is dropped or altered.
// Without the macro error_o is tied low and no checker logic is built.
module iob_be_mem_sim #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned STALL_EVERY = 0,
   parameter int unsigned STALL_LEN   = 2
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                valid_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   output logic                ready_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                rvalid_o,
   output logic                error_o
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned ACC_W  = (STALL_EVERY < 2) ? 1 : $clog2(STALL_EVERY + 1);

   localparam logic [ACC_W-1:0] ACC_LAST    = ACC_W'(STALL_EVERY - 1);
   localparam logic [3:0]       STALL_LEN_C = 4'(STALL_LEN);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              wr_accept;
   logic              rd_accept;
   logic [DATA_W-1:0] mem_rd;
   logic [DATA_W-1:0] wr_word;

   assign accept    = valid_i & ready_o;
   assign wr_accept = accept & (|wstrb_i);
   assign rd_accept = accept & ~(|wstrb_i);
   assign mem_rd    = mem[addr_i];

   // Merge strobed bytes of the write data into the currently stored word
   always_comb begin
      wr_word = mem_rd;
      for (int unsigned b = 0; b < STRB_W; b++) begin
         if (wstrb_i[b]) begin
            wr_word[b*8 +: 8] = wdata_i[b*8 +: 8];
         end
      end
   end

   // Memory array write port; contents intentionally survive reset
   always_ff @(posedge clk_i) begin
      if (wr_accept) begin
         mem[addr_i] <= wr_word;
      end
   end

   // Read response pipeline: stage 0 samples memory at the acceptance edge,
   // the last stage drives rvalid_o/rdata_o. Data only advances alongside a
   // valid bit, so rdata_o holds the last response between pulses.
   for (genvar s = 0; s < RD_LAT; s++) begin : g_stage
      logic              v;
      logic [DATA_W-1:0] d;
      logic              in_v;
      logic [DATA_W-1:0] in_d;

      if (s == 0) begin : g_head
         assign in_v = rd_accept;
         assign in_d = mem_rd;
      end else begin : g_link
         assign in_v = g_stage[s-1].v;
         assign in_d = g_stage[s-1].d;
      end

      // One pipeline stage; reset drops any in-flight response
      always_ff @(posedge clk_i or negedge arst_n_i) begin
         if (!arst_n_i) begin
            v <= 1'b0;
            d <= '0;
         end else begin
            v <= in_v;
            if (in_v) begin
               d <= in_d;
            end
         end
      end
   end

   assign rvalid_o = g_stage[RD_LAT-1].v;
   assign rdata_o  = g_stage[RD_LAT-1].d;

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc_cnt;
   logic [ACC_W-1:0] acc_nxt;
   logic [3:0]       stall_cnt;
   logic [3:0]       stall_nxt;

   // Stall FSM state, counters and registered ready_o
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state     <= ST_RUN;
         acc_cnt   <= '0;
         stall_cnt <= '0;
         ready_o   <= 1'b1;
      end else begin
         state     <= state_nxt;
         acc_cnt   <= acc_nxt;
         stall_cnt <= stall_nxt;
         ready_o   <= (state_nxt == ST_RUN);
      end
   end

   // Stall FSM next state: count acceptances in RUN, count down in STALL
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc_cnt;
      stall_nxt = stall_cnt;
      case (state)
         ST_RUN: begin
            if (STALL_EVERY != 0 && accept) begin
               acc_nxt = acc_cnt + 1'b1;
               if (acc_cnt == ACC_LAST) begin
                  state_nxt = ST_STALL;
                  stall_nxt = STALL_LEN_C;
               end
            end
         end
         ST_STALL: begin
            if (stall_cnt <= 4'd1) begin
               state_nxt = ST_RUN;
               acc_nxt   = '0;
               stall_nxt = '0;
            end else begin
               stall_nxt = stall_cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = ST_RUN;
            acc_nxt   = '0;
            stall_nxt = '0;
         end
      endcase
   end

`ifdef IOB_BE_MEM_SIM_PROTOCOL_CHECK_EN
   logic              hold_v;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_wdata;
   logic [STRB_W-1:0] hold_wstrb;
   logic              error_q;
   logic              viol_drop;
   logic              viol_addr;
   logic              viol_wdata;
   logic              viol_wstrb;

   assign viol_drop  = hold_v & ~valid_i;
   assign viol_addr  = hold_v & valid_i & (addr_i  != hold_addr);
   assign viol_wdata = hold_v & valid_i & (wdata_i != hold_wdata);
   assign viol_wstrb = hold_v & valid_i & (wstrb_i != hold_wstrb);

   // Capture each stalled request and latch any change on the following cycle
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         hold_v     <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= '0;
         hold_wstrb <= '0;
         error_q    <= 1'b0;
      end else begin
         hold_v <= valid_i & ~ready_o;
         if (valid_i && !ready_o) begin
            hold_addr  <= addr_i;
            hold_wdata <= wdata_i;
            hold_wstrb <= wstrb_i;
         end
         if (viol_drop || viol_addr || viol_wdata || viol_wstrb) begin
            error_q <= 1'b1;
         end
      end
   end

`ifndef SYNTHESIS
   // Report which field of the stalled request misbehaved
   always_ff @(posedge clk_i) begin
      if (arst_n_i) begin
         if (viol_drop)  $display("%0t iob_be_mem_sim: protocol error, valid_i dropped while stalled", $time);
         if (viol_addr)  $display("%0t iob_be_mem_sim: protocol error, addr_i changed while stalled", $time);
         if (viol_wdata) $display("%0t iob_be_mem_sim: protocol error, wdata_i changed while stalled", $time);
         if (viol_wstrb) $display("%0t iob_be_mem_sim: protocol error, wstrb_i changed while stalled", $time);
      end
   end
`endif

   assign error_o = error_q;
`else
   assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_be_mem_sim.sv
// Self-checking bench for iob_be_mem_sim: four instances cover the basic
// write/read path, deep read latency, periodic stalls, reset mid-read and the
// optional protocol checker.
module tb_iob_be_mem_sim;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic rst3_n;

   int checks   = 0;
   int failures = 0;

`ifdef IOB_BE_MEM_SIM_PROTOCOL_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   // instance 0: RD_LAT=1, no stalls
   logic v0, rdy0, rv0, er0;
   logic [11:0] a0;
   logic [31:0] d0, rd0;
   logic [3:0]  s0;
   // instance 1: RD_LAT=4, no stalls
   logic v1, rdy1, rv1, er1;
   logic [11:0] a1;
   logic [31:0] d1, rd1;
   logic [3:0]  s1;
   // instance 2: RD_LAT=1, STALL_EVERY=3, STALL_LEN=2
   logic v2, rdy2, rv2, er2;
   logic [11:0] a2;
   logic [31:0] d2, rd2;
   logic [3:0]  s2;
   // instance 3: RD_LAT=3, STALL_EVERY=1, STALL_LEN=2, own reset
   logic v3, rdy3, rv3, er3;
   logic [11:0] a3;
   logic [31:0] d3, rd3;
   logic [3:0]  s3;

   iob_be_mem_sim #(.DATA_W(32), .ADDR_W(12), .RD_LAT(1), .STALL_EVERY(0), .STALL_LEN(2)) u0 (
      .clk_i(clk), .arst_n_i(rst_n), .valid_i(v0), .addr_i(a0), .wdata_i(d0), .wstrb_i(s0),
      .ready_o(rdy0), .rdata_o(rd0), .rvalid_o(rv0), .error_o(er0));

   iob_be_mem_sim #(.DATA_W(32), .ADDR_W(12), .RD_LAT(4), .STALL_EVERY(0), .STALL_LEN(2)) u1 (
      .clk_i(clk), .arst_n_i(rst_n), .valid_i(v1), .addr_i(a1), .wdata_i(d1), .wstrb_i(s1),
      .ready_o(rdy1), .rdata_o(rd1), .rvalid_o(rv1), .error_o(er1));

   iob_be_mem_sim #(.DATA_W(32), .ADDR_W(12), .RD_LAT(1), .STALL_EVERY(3), .STALL_LEN(2)) u2 (
      .clk_i(clk), .arst_n_i(rst_n), .valid_i(v2), .addr_i(a2), .wdata_i(d2), .wstrb_i(s2),
      .ready_o(rdy2), .rdata_o(rd2), .rvalid_o(rv2), .error_o(er2));

   iob_be_mem_sim #(.DATA_W(32), .ADDR_W(12), .RD_LAT(3), .STALL_EVERY(1), .STALL_LEN(2)) u3 (
      .clk_i(clk), .arst_n_i(rst3_n), .valid_i(v3), .addr_i(a3), .wdata_i(d3), .wstrb_i(s3),
      .ready_o(rdy3), .rdata_o(rd3), .rvalid_o(rv3), .error_o(er3));

   typedef struct {
      logic        v;
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        ev;
      logic [31:0] ed;
   } vec_t;

   localparam int NV = 15;
   vec_t tbl [NV];

   bit exp_rdy [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [11:0] rb_addr [2] = '{12'h007, 12'h003};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present a request on instance 3 and hold it until accepted (bounded)
   task automatic u3_issue(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      bit ok;
      ok = 1'b0;
      a3 = a;
      d3 = d;
      s3 = s;
      v3 = 1'b1;
      for (int n = 0; n < 10; n++) begin
         if (rdy3 === 1'b1) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      v3 = 1'b0;
      chk("u3_accept", 32'(ok), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n_acc;
      bit  acc;
      bit  ok;

      tbl[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000};
      tbl[1]  = '{1'b1, 12'h010, 32'h00000000, 4'h0, 1'b1, 32'hDEADBEEF};
      tbl[2]  = '{1'b0, 12'h010, 32'h00000000, 4'h0, 1'b0, 32'hDEADBEEF};
      tbl[3]  = '{1'b1, 12'h020, 32'h11223344, 4'hF, 1'b0, 32'hDEADBEEF};
      tbl[4]  = '{1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 1'b0, 32'hDEADBEEF};
      tbl[5]  = '{1'b1, 12'h020, 32'h00000000, 4'h0, 1'b1, 32'h11BB33DD};
      tbl[6]  = '{1'b1, 12'hFFF, 32'h12345678, 4'hF, 1'b0, 32'h11BB33DD};
      tbl[7]  = '{1'b1, 12'h000, 32'hCAFEF00D, 4'hF, 1'b0, 32'h11BB33DD};
      tbl[8]  = '{1'b1, 12'hFFF, 32'h00000000, 4'h0, 1'b1, 32'h12345678};
      tbl[9]  = '{1'b1, 12'h000, 32'h00000000, 4'h0, 1'b1, 32'hCAFEF00D};
      tbl[10] = '{1'b1, 12'h020, 32'h77000000, 4'h8, 1'b0, 32'hCAFEF00D};
      tbl[11] = '{1'b1, 12'h020, 32'h00000000, 4'h0, 1'b1, 32'h77BB33DD};
      tbl[12] = '{1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h77BB33DD};
      tbl[13] = '{1'b1, 12'h010, 32'h00005A00, 4'h2, 1'b0, 32'h77BB33DD};
      tbl[14] = '{1'b1, 12'h010, 32'h00000000, 4'h0, 1'b1, 32'hDEAD5AEF};

      v0 = 1'b0; a0 = '0; d0 = '0; s0 = '0;
      v1 = 1'b0; a1 = '0; d1 = '0; s1 = '0;
      v2 = 1'b0; a2 = '0; d2 = '0; s2 = '0;
      v3 = 1'b0; a3 = '0; d3 = '0; s3 = '0;
      rst_n  = 1'b0;
      rst3_n = 1'b0;
      repeat (2) tick();

      // reset values on every instance
      chk("rst_ready0", 32'(rdy0), 32'd1);  chk("rst_rvalid0", 32'(rv0), 32'd0);
      chk("rst_rdata0", rd0, 32'd0);        chk("rst_error0", 32'(er0), 32'd0);
      chk("rst_ready1", 32'(rdy1), 32'd1);  chk("rst_rvalid1", 32'(rv1), 32'd0);
      chk("rst_rdata1", rd1, 32'd0);        chk("rst_error1", 32'(er1), 32'd0);
      chk("rst_ready2", 32'(rdy2), 32'd1);  chk("rst_rvalid2", 32'(rv2), 32'd0);
      chk("rst_rdata2", rd2, 32'd0);        chk("rst_error2", 32'(er2), 32'd0);
      chk("rst_ready3", 32'(rdy3), 32'd1);  chk("rst_rvalid3", 32'(rv3), 32'd0);
      chk("rst_rdata3", rd3, 32'd0);        chk("rst_error3", 32'(er3), 32'd0);

      rst_n  = 1'b1;
      rst3_n = 1'b1;
      tick();

      // instance 0: table of writes/reads, one per edge, RD_LAT=1
      for (int i = 0; i < NV; i++) begin
         v0 = tbl[i].v;
         a0 = tbl[i].a;
         d0 = tbl[i].d;
         s0 = tbl[i].s;
         tick();
         chk($sformatf("u0_ready_v%0d", i), 32'(rdy0), 32'd1);
         chk($sformatf("u0_rvalid_v%0d", i), 32'(rv0), 32'(tbl[i].ev));
         chk($sformatf("u0_rdata_v%0d", i), rd0, tbl[i].ed);
      end
      v0 = 1'b0;
      s0 = '0;

      // instance 1: preload 0..3, then four back-to-back reads, RD_LAT=4
      for (int i = 0; i < 4; i++) begin
         v1 = 1'b1;
         a1 = 12'(i);
         d1 = 32'hA0 + 32'(i);
         s1 = 4'hF;
         tick();
      end
      for (int c = 0; c < 10; c++) begin
         if (c < 4) begin
            v1 = 1'b1;
            a1 = 12'(c);
            s1 = 4'h0;
         end else begin
            v1 = 1'b0;
         end
         tick();
         chk($sformatf("u1_rvalid_c%0d", c), 32'(rv1), 32'((c >= 3) && (c <= 6)));
         if (c < 3)
            chk($sformatf("u1_rdata_c%0d", c), rd1, 32'h0);
         else if (c <= 6)
            chk($sformatf("u1_rdata_c%0d", c), rd1, 32'hA0 + 32'(c - 3));
         else
            chk($sformatf("u1_rdata_c%0d", c), rd1, 32'hA3);
      end

      // instance 2: valid held high for 8 writes through the stall windows
      n_acc = 0;
      v2 = 1'b1;
      a2 = 12'h000;
      d2 = 32'h100;
      s2 = 4'hF;
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("u2_ready_c%0d", k), 32'(rdy2), 32'(exp_rdy[k]));
         acc = v2 && rdy2;
         tick();
         if (acc) begin
            n_acc++;
            if (n_acc == 8) begin
               v2 = 1'b0;
            end else begin
               a2 = 12'(n_acc);
               d2 = 32'h100 + 32'(n_acc);
            end
         end
      end
      v2 = 1'b0;
      chk("u2_accept_count", 32'(n_acc), 32'd8);

      // read back two of the stalled writes
      for (int r = 0; r < 2; r++) begin
         ok = 1'b0;
         a2 = rb_addr[r];
         s2 = 4'h0;
         v2 = 1'b1;
         for (int n = 0; n < 10; n++) begin
            if (rdy2 === 1'b1) begin
               ok = 1'b1;
               tick();
               break;
            end
            tick();
         end
         v2 = 1'b0;
         chk($sformatf("u2_rd_accept%0d", r), 32'(ok), 32'd1);
         chk($sformatf("u2_rd_rvalid%0d", r), 32'(rv2), 32'd1);
         chk($sformatf("u2_rd_rdata%0d", r), rd2, 32'h100 + 32'(rb_addr[r]));
      end
      chk("u2_error_clean", 32'(er2), 32'd0);

      // instance 3: RD_LAT=3 response timing with a stall after each request
      u3_issue(12'h005, 32'h00000055, 4'hF);
      chk("u3_stall_entry", 32'(rdy3), 32'd0);
      u3_issue(12'h005, 32'h0, 4'h0);
      chk("u3_rvalid_l0", 32'(rv3), 32'd0);
      tick();
      chk("u3_rvalid_l1", 32'(rv3), 32'd0);
      tick();
      chk("u3_rvalid_l2", 32'(rv3), 32'd1);
      chk("u3_rdata_l2", rd3, 32'h00000055);
      tick();
      chk("u3_rvalid_l3", 32'(rv3), 32'd0);
      chk("u3_rdata_hold", rd3, 32'h00000055);

      // instance 3: address changes while stalled
      u3_issue(12'h0A0, 32'h00000001, 4'hF);
      chk("u3_stall_before_viol", 32'(rdy3), 32'd0);
      v3 = 1'b1;
      a3 = 12'h0B0;
      d3 = 32'h00000002;
      s3 = 4'hF;
      tick();
      a3 = 12'h0B1;
      tick();
      chk("u3_error_set", 32'(er3), 32'(EXP_ERR));
      v3 = 1'b0;
      repeat (3) tick();
      chk("u3_error_sticky", 32'(er3), 32'(EXP_ERR));

      // instance 3: reset one cycle after a read acceptance drops the read
      u3_issue(12'h005, 32'h0, 4'h0);
      tick();
      rst3_n = 1'b0;
      #1;
      chk("u3_midrst_rvalid", 32'(rv3), 32'd0);
      chk("u3_midrst_ready", 32'(rdy3), 32'd1);
      chk("u3_midrst_error", 32'(er3), 32'd0);
      chk("u3_midrst_rdata", rd3, 32'd0);
      repeat (2) tick();
      rst3_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk($sformatf("u3_post_rvalid_c%0d", c), 32'(rv3), 32'd0);
         chk($sformatf("u3_post_ready_c%0d", c), 32'(rdy3), 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
